uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage, 8N1 by default, the downstream counterpart to the team's UART transmitter on the Vaaman APB bus. It synchronises the asynchronous `rx` line and rejects start-bit glitches. It samples each bit at its midpoint and presents each received byte on `dout` with a one-cycle `valid` strobe for the APB register bank. Framing errors, and parity errors when that option is compiled in, are flagged and never delivered as data.

---
 rtl/uart_receiver.sv | 202 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : UART receive stage, 8N1 by default, 8E1 when UART_RX_PARITY_EN
//            is defined. Synchronises rx, rejects start glitches, samples
//            mid-bit and flags framing/parity errors instead of delivering data.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_STOP      = 3'd4;
    localparam logic [2:0] c_ST_WAIT_HIGH = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY    = 3'd3;
    localparam logic [2:0] c_ST_AFTER_DATA = c_ST_PARITY;
`else
    localparam logic [2:0] c_ST_AFTER_DATA = c_ST_STOP;
`endif

    logic               r_rx_meta;
    logic               r_rx_s;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_dout;
    logic               r_valid;
    logic               r_frame_err;
    logic               w_half_done;
    logic               w_bit_done;
    logic               w_take_bit;
    logic               w_good;
    logic               w_ferr;
`ifdef UART_RX_PARITY_EN
    logic               r_par_bit;
    logic               r_parity_err;
    logic               w_take_par;
    logic               w_perr;
    logic               w_par_bad;
`endif

    // Both flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_half_done = (r_cnt == c_HALF_LAST);
    assign w_bit_done  = (r_cnt == c_BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!r_rx_s) w_state_nxt = c_ST_START;
            end
            c_ST_START: begin
                if (w_half_done) w_state_nxt = r_rx_s ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_bit_done && (r_idx == 3'd7)) w_state_nxt = c_ST_AFTER_DATA;
            end
`ifdef UART_RX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_done) w_state_nxt = c_ST_STOP;
            end
`endif
            // Leaving STOP at the sample point gives half a bit of slack
            // to catch a back-to-back start edge.
            c_ST_STOP: begin
                if (w_bit_done) w_state_nxt = r_rx_s ? c_ST_IDLE : c_ST_WAIT_HIGH;
            end
            c_ST_WAIT_HIGH: begin
                if (r_rx_s) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_take_bit = 1'b0;
        w_good     = 1'b0;
        w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_take_par = 1'b0;
        w_perr     = 1'b0;
`endif
        case (r_state)
            c_ST_DATA: w_take_bit = w_bit_done;
`ifdef UART_RX_PARITY_EN
            c_ST_PARITY: w_take_par = w_bit_done;
`endif
            c_ST_STOP: begin
                if (w_bit_done) begin
                    if (!r_rx_s) begin
                        w_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (w_par_bad) begin
                        w_perr = 1'b1;
`endif
                    end else begin
                        w_good = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Bit counter restarts on every state change and at every bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == c_ST_IDLE) || w_bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else if (r_state == c_ST_IDLE) begin
            r_idx   <= 3'd0;
        end else if (w_take_bit) begin
            r_shift[r_idx] <= r_rx_s;
            r_idx          <= r_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= w_good;
            r_frame_err <= w_ferr;
            if (w_good) r_dout <= r_shift;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the received bit must equal the XOR of the data bits.
    assign w_par_bad = (r_par_bit != (^r_shift));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr;
            if (w_take_par) r_par_bit <= r_rx_s;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign dout      = r_dout;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// Bench for uart_receiver: builds the whole rx/rst waveform up front, decodes it
// frame by frame into expected per-cycle outputs, then drives it and compares.
module tb_uart_receiver;

    localparam int N = 16;
    localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int MAXT = 20000;
    localparam int XO = 3 + H + (9 + PAR) * N;  // frame start -> flag cycle
    localparam int EV_NONE = 0, EV_VALID = 1, EV_FERR = 2, EV_PERR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       valid, frame_err, parity_err, rx_busy;

    uart_receiver #(.CLKS_PER_BIT(N)) dut (
        .clk(clk), .rst(rst), .rx(rx), .dout(dout), .valid(valid),
        .frame_err(frame_err), .parity_err(parity_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    bit         rxw   [MAXT];
    bit         rstw  [MAXT];
    int         ev    [MAXT];
    logic [7:0] evd   [MAXT];
    bit         busyw [MAXT];
    int wp = 0;
    int cyc = 0;
    bit running = 1'b0;
    int checks = 0;
    int failures = 0;

    task automatic put(input bit v, input int n);
        for (int k = 0; k < n; k++) begin
            if (wp < MAXT) begin
                rxw[wp] = v; rstw[wp] = 1'b0; wp++;
            end
        end
    endtask

    task automatic put_rst(input int n);
        for (int k = 0; k < n; k++) begin
            if (wp < MAXT) begin
                rxw[wp] = 1'b1; rstw[wp] = 1'b1; wp++;
            end
        end
    endtask

    task automatic frame(input logic [7:0] d, input int p, input bit par_flip,
                         input bit stop_v, input int stop_len);
        put(1'b0, p);
        for (int k = 0; k < 8; k++) put(d[k], p);
        if (PAR == 1) put((^d) ^ par_flip, p);
        put(stop_v, stop_len);
    endtask

    // Line as the receiver sees it after the two-flop synchroniser.
    function automatic bit rs(input int i);
        if (i < 2 || i - 2 >= MAXT) return 1'b1;
        return rxw[i - 2];
    endfunction

    function automatic int first_rst(input int a, input int b);
        for (int q = a; q <= b && q < MAXT; q++) if (rstw[q]) return q;
        return -1;
    endfunction

    task automatic mark_busy(input int a, input int b);
        for (int q = a; q <= b && q < MAXT; q++) busyw[q] = 1'b1;
    endtask

    // Frame-level decode: start seen in cycle i, START entered at e=i+1,
    // each sample reads the line in the cycle before its sample edge.
    task automatic decode();
        int i, e, x, endc, q, j, kind;
        logic [7:0] d;
        bit pb, st;
        i = 0;
        d = 8'h00;
        while (i < wp) begin
            if (rstw[i] || rs(i)) begin
                i++;
            end else begin
                e = i + 1;
                if (rs(e + H - 1)) begin
                    endc = e + H - 1; x = endc; kind = EV_NONE;
                end else begin
                    for (int k = 0; k < 8; k++) d[k] = rs(e + H + (k + 1) * N - 1);
                    pb = rs(e + H + 9 * N - 1);
                    x  = e + H + (9 + PAR) * N;
                    st = rs(x - 1);
                    if (st) begin
                        endc = x - 1;
                        kind = (PAR == 1 && pb != (^d)) ? EV_PERR : EV_VALID;
                    end else begin
                        j = x;
                        while (j < wp && !rs(j)) j++;
                        endc = j; kind = EV_FERR;
                    end
                end
                q = first_rst(e, (endc > x) ? endc : x);
                if (q >= 0) begin
                    mark_busy(e, q - 1);
                    i = q;
                end else begin
                    mark_busy(e, endc);
                    if (kind != EV_NONE && x < MAXT) begin
                        ev[x] = kind; evd[x] = d;
                    end
                    i = endc + 1;
                end
            end
        end
    endtask

    task automatic pin(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL pin %s: model gives %0d, hand value %0d", name, act, req);
        end
    endtask

    initial begin : compare_proc
        logic [7:0]  m_dout;
        logic [11:0] act_v, exp_v;
        int k;
        m_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (running) begin
                k = cyc;
                if (rstw[k]) m_dout = 8'h00;
                else if (ev[k] == EV_VALID) m_dout = evd[k];
                exp_v = {ev[k] == EV_VALID, ev[k] == EV_FERR, ev[k] == EV_PERR, busyw[k], m_dout};
                act_v = {valid, frame_err, parity_err, rx_busy, dout};
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL cycle %0d {valid,frame_err,parity_err,rx_busy,dout}: got %03h expected %03h",
                             k, act_v, exp_v);
                end
            end
        end
    end

    initial begin : stim_proc
        int s1, s2, s2b, s3, s3b, s4, s4b, s5, s5r, s5b, rise4;
`ifdef UART_RX_PARITY_EN
        int s6, s6b;
`endif
        for (int i = 0; i < MAXT; i++) begin
            ev[i] = EV_NONE; evd[i] = 8'h00; busyw[i] = 1'b0; rxw[i] = 1'b1; rstw[i] = 1'b0;
        end
        put_rst(4); put(1'b1, 10);
        s1 = wp;  frame(8'hA5, N, 1'b0, 1'b1, N); put(1'b1, 20);
        s2 = wp;  frame(8'h00, N, 1'b0, 1'b1, N); frame(8'hFF, N, 1'b0, 1'b1, N); put(1'b1, 20);
        s2b = wp; frame(8'h80, N + 1, 1'b0, 1'b1, N + 1); frame(8'hFF, N + 1, 1'b0, 1'b1, N + 1);
        put(1'b1, 20);
        s3 = wp;  put(1'b0, 5); put(1'b1, 20);
        s3b = wp; frame(8'h3C, N, 1'b0, 1'b1, N); put(1'b1, 20);
        s4 = wp;  frame(8'h81, N, 1'b0, 1'b0, N + 40);
        rise4 = wp; put(1'b1, 20);
        s4b = wp; frame(8'h3C, N, 1'b0, 1'b1, N); put(1'b1, 20);
        s5 = wp;  put(1'b0, N); put(1'b1, 4 * N + 4);
        s5r = wp; put_rst(3); put(1'b1, 20);
        s5b = wp; frame(8'h5A, N, 1'b0, 1'b1, N); put(1'b1, 20);
`ifdef UART_RX_PARITY_EN
        s6 = wp;  frame(8'h07, N, 1'b0, 1'b1, N); put(1'b1, 20);
        s6b = wp; frame(8'h07, N, 1'b1, 1'b1, N); put(1'b1, 20);
`endif
        for (int r = 0; r < 30; r++) begin
            int sel;
            logic [7:0] d;
            sel = int'($urandom_range(0, 9));
            d = 8'($urandom);
            if (sel == 0) begin
                put(1'b0, int'($urandom_range(1, 7))); put(1'b1, 20);
            end else if (sel == 1) begin
                frame(d, N, 1'b0, 1'b0, N + int'($urandom_range(0, 30))); put(1'b1, 20);
            end else begin
                frame(d, N, bit'($urandom_range(0, 4) == 0), 1'b1, N);
                put(1'b1, int'($urandom_range(0, 20)));
            end
        end
        put(1'b1, 50);

        decode();

        pin("s1_kind", ev[s1 + XO], EV_VALID);
        pin("s1_data", int'(evd[s1 + XO]), 8'hA5);
        pin("s1_busy_last", int'(busyw[s1 + XO - 1]), 1);
        pin("s1_busy_drop", int'(busyw[s1 + XO]), 0);
        pin("s2_first", int'(evd[s2 + XO]), 8'h00);
        pin("s2_second_kind", ev[s2 + (10 + PAR) * N + XO], EV_VALID);
        pin("s2_second", int'(evd[s2 + (10 + PAR) * N + XO]), 8'hFF);
        pin("s3_busy_pre", int'(busyw[s3 + 2]), 0);
        pin("s3_busy_first", int'(busyw[s3 + 3]), 1);
        pin("s3_busy_end", int'(busyw[s3 + 10]), 1);
        pin("s3_busy_drop", int'(busyw[s3 + 11]), 0);
        pin("s3_next", int'(evd[s3b + XO]), 8'h3C);
        pin("s4_kind", ev[s4 + XO], EV_FERR);
        pin("s4_rise", rise4, s4 + (10 + PAR) * N + 40);
        pin("s4_busy_hold", int'(busyw[rise4 + 2]), 1);
        pin("s4_busy_drop", int'(busyw[rise4 + 3]), 0);
        pin("s4_next_kind", ev[s4b + XO], EV_VALID);
        pin("s5_busy_before_rst", int'(busyw[s5r - 1]), 1);
        pin("s5_busy_in_rst", int'(busyw[s5r]), 0);
        pin("s5_no_flag", ev[s5 + XO], EV_NONE);
        pin("s5_next", int'(evd[s5b + XO]), 8'h5A);
`ifdef UART_RX_PARITY_EN
        pin("s6_good_kind", ev[s6 + XO], EV_VALID);
        pin("s6_good_data", int'(evd[s6 + XO]), 8'h07);
        pin("s6_bad_kind", ev[s6b + XO], EV_PERR);
`endif

        for (int i = 0; i < wp; i++) begin
            @(posedge clk);
            #1;
            rx = rxw[i];
            rst = rstw[i];
            cyc = i;
            running = 1'b1;
        end
        @(posedge clk);
        #1;
        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
